// File: rtl/scrambler_pkg.sv
// Shared constants and helpers for the x^58 + x^39 + 1 multiplicative scrambler pair.
// History convention: hist[0] is the most recent serial bit, hist[k-1] is bit n-k.
package scrambler_pkg;

  localparam int HIST_LEN = 58;
  localparam int TAP_A    = 39;
  localparam int TAP_B    = 58;
  localparam int MAX_W    = 32;

  localparam logic [1:0] DW_8      = 2'b00;
  localparam logic [1:0] DW_16     = 2'b01;
  localparam logic [1:0] DW_32     = 2'b10;
  localparam logic [1:0] DW_32_ALT = 2'b11;

  function automatic int width_of(input logic [1:0] sel);
    case (sel)
      DW_8:             width_of = 8;
      DW_16:            width_of = 16;
      DW_32, DW_32_ALT: width_of = 32;
      default:          width_of = 32;
    endcase
  endfunction

  // One serial step of the polynomial: d XOR bit[n-39] XOR bit[n-58].
  function automatic logic lfsr_bit(input logic d, input logic tap_a, input logic tap_b);
    return d ^ tap_a ^ tap_b;
  endfunction

endpackage

// File: rtl/descrambler.sv
// Self-synchronizing descrambler for x^58 + x^39 + 1, fixed word width, latency 1.
// History always shifts in the received bits so it resynchronizes after 58 bits.
module descrambler
  import scrambler_pkg::*;
#(
  parameter int WORDWIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 bypass,
  input  logic [WORDWIDTH-1:0] din,
  output logic [WORDWIDTH-1:0] dout
);

  logic [HIST_LEN-1:0]  r_hist;
  logic [WORDWIDTH-1:0] r_dout;
  logic [HIST_LEN-1:0]  w_hist_nxt;
  logic [WORDWIDTH-1:0] w_word;

  always_comb begin
    w_hist_nxt = r_hist;
    w_word     = '0;
    for (int i = 0; i < WORDWIDTH; i++) begin
      w_word[i]  = bypass ? din[i]
                          : lfsr_bit(din[i], w_hist_nxt[TAP_A-1], w_hist_nxt[TAP_B-1]);
      w_hist_nxt = {w_hist_nxt[HIST_LEN-2:0], din[i]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hist <= '0;
      r_dout <= '0;
    end else begin
      r_hist <= w_hist_nxt;
      r_dout <= w_word;
    end
  end

  assign dout = r_dout;

endmodule

// File: rtl/scrambler.sv
// Multiplicative scrambler for x^58 + x^39 + 1 with runtime 8/16/32-bit word width.
// Bits go LSB first; intra-word taps see bits computed earlier in the same word.
module scrambler
  import scrambler_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  dataWidth,
  input  logic [31:0] din,
  input  logic        bypass,
  output logic [31:0] dout
);

  logic [HIST_LEN-1:0] r_hist;
  logic [MAX_W-1:0]    r_dout;
  logic [HIST_LEN-1:0] w_hist_nxt;
  logic [MAX_W-1:0]    w_word;
  int                  w_width;

  // Bypassed bits still enter the history so a receiver stays in lock.
  always_comb begin
    w_width    = width_of(dataWidth);
    w_hist_nxt = r_hist;
    w_word     = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < w_width) begin
        w_word[i]  = bypass ? din[i]
                            : lfsr_bit(din[i], w_hist_nxt[TAP_A-1], w_hist_nxt[TAP_B-1]);
        w_hist_nxt = {w_hist_nxt[HIST_LEN-2:0], w_word[i]};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hist <= '0;
      r_dout <= '0;
    end else begin
      r_hist <= w_hist_nxt;
      r_dout <= w_word;
    end
  end

  assign dout = r_dout;

endmodule

// File: tb/tb_scrambler.sv
// Directed bench for scrambler plus 8/16/32-bit descramblers on a shared link
// with a single-bit error injection mask.
module tb_scrambler;

  // ---------------- clock / reset ----------------
  logic        clk;
  logic        reset;
  logic [1:0]  data_width;
  logic [31:0] din;
  logic        scr_bypass;
  logic        dsc_bypass;
  logic [31:0] scr_dout;
  logic [31:0] err_mask;
  logic [31:0] link;
  logic [7:0]  d8;
  logic [15:0] d16;
  logic [31:0] d32;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp8 [8];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign link = scr_dout ^ err_mask;

  scrambler u_scr (
    .clk(clk), .reset(reset), .dataWidth(data_width),
    .din(din), .bypass(scr_bypass), .dout(scr_dout)
  );

  descrambler #(.WORDWIDTH(8)) u_dsc8 (
    .clk(clk), .reset(reset), .bypass(dsc_bypass), .din(link[7:0]), .dout(d8)
  );

  descrambler #(.WORDWIDTH(16)) u_dsc16 (
    .clk(clk), .reset(reset), .bypass(dsc_bypass), .din(link[15:0]), .dout(d16)
  );

  descrambler #(.WORDWIDTH(32)) u_dsc32 (
    .clk(clk), .reset(reset), .bypass(dsc_bypass), .din(link), .dout(d32)
  );

  // ---------------- helpers / driver tasks ----------------
  function automatic logic [31:0] mask_of(input logic [1:0] dw);
    case (dw)
      2'b00:   mask_of = 32'h0000_00FF;
      2'b01:   mask_of = 32'h0000_FFFF;
      default: mask_of = 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic logic [31:0] dsc_out(input logic [1:0] dw);
    case (dw)
      2'b00:   dsc_out = {24'h0, d8};
      2'b01:   dsc_out = {16'h0, d16};
      default: dsc_out = d32;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] w);
    din = w;
    step();
  endtask

  // Reset is raised away from any clock edge, so zero outputs prove it is asynchronous.
  task automatic apply_reset(input string tag);
    reset      = 1'b1;
    din        = '0;
    scr_bypass = 1'b0;
    dsc_bypass = 1'b0;
    err_mask   = '0;
    #2;
    check({tag, "_scr"}, scr_dout, 32'h0);
    check({tag, "_dsc"}, d32 | {16'h0, d16} | {24'h0, d8}, 32'h0);
    step();
    reset = 1'b0;
  endtask

  // Counter through scrambler -> link -> descrambler. Descrambler bypass follows the
  // scrambler bypass one word later so it lines up with the words on the link.
  task automatic run_loop(input string tag, input logic [1:0] dw, input int n,
                          input int tog_at, input int inj_at);
    logic [31:0] m;
    logic [31:0] w;
    logic [31:0] e;
    apply_reset(tag);
    data_width = dw;
    m = mask_of(dw);
    exp_q.delete();
    for (int k = 0; k < n; k++) begin
      w = 32'h1234_00F8 + k;
      e = w & m;
      if (k == inj_at)     e = e ^ 32'h0000_0020;
      if (k == inj_at + 1) e = e ^ 32'h8000_1000;
      exp_q.push_back(e);
      din        = w;
      scr_bypass = (k >= tog_at);
      step();
      if (k >= tog_at) check($sformatf("%s_scr_byp%0d", tag, k), scr_dout, w & m);
      err_mask   = (k == inj_at) ? 32'h0000_0020 : 32'h0;
      dsc_bypass = (k >= tog_at);
      if (k >= 1) check($sformatf("%s_dsc%0d", tag, k - 1), dsc_out(dw), exp_q.pop_front());
    end
    din = '0;
    step();
    err_mask = '0;
    check($sformatf("%s_dsc%0d", tag, n - 1), dsc_out(dw), exp_q.pop_front());
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset      = 1'b1;
    data_width = 2'b10;
    din        = '0;
    scr_bypass = 1'b0;
    dsc_bypass = 1'b0;
    err_mask   = '0;
    exp8 = '{32'h01, 32'h00, 32'h00, 32'h00, 32'h80, 32'h00, 32'h00, 32'h04};

    // all-zero input stays zero
    apply_reset("rst_zero");
    data_width = 2'b10;
    for (int k = 0; k < 4; k++) begin
      send(32'h0);
      check($sformatf("zero32_%0d", k), scr_dout, 32'h0);
    end

    // 32-bit impulse: taps at bit 39, 58 and 78
    apply_reset("rst_imp32");
    data_width = 2'b10;
    send(32'h1); check("imp32_w0", scr_dout, 32'h0000_0001);
    send(32'h0); check("imp32_w1", scr_dout, 32'h0400_0080);
    send(32'h0); check("imp32_w2", scr_dout, 32'h0000_4000);

    // 8-bit impulse, upper din bits must be ignored
    apply_reset("rst_imp8");
    data_width = 2'b00;
    send(32'hABCD_EF01);
    check("imp8_w0", scr_dout, exp8[0]);
    for (int k = 1; k < 8; k++) begin
      send(32'h0);
      check($sformatf("imp8_w%0d", k), scr_dout, exp8[k]);
    end

    // 16-bit impulse
    apply_reset("rst_imp16");
    data_width = 2'b01;
    send(32'h55AA_0001); check("imp16_w0", scr_dout, 32'h0000_0001);
    send(32'h0);         check("imp16_w1", scr_dout, 32'h0000_0000);
    send(32'h0);         check("imp16_w2", scr_dout, 32'h0000_0080);
    send(32'h0);         check("imp16_w3", scr_dout, 32'h0000_0400);

    // width changes mid-stream keep history
    apply_reset("rst_wchg");
    data_width = 2'b10; send(32'h1); check("wchg_32",   scr_dout, 32'h0000_0001);
    data_width = 2'b00; send(32'h0); check("wchg_8a",   scr_dout, 32'h0000_0080);
    data_width = 2'b01; send(32'h0); check("wchg_16",   scr_dout, 32'h0000_0000);
    data_width = 2'b00; send(32'h0); check("wchg_8b",   scr_dout, 32'h0000_0004);
    data_width = 2'b11; send(32'h0); check("wchg_32b",  scr_dout, 32'h0000_4000);

    // bypass passes data and still feeds history
    apply_reset("rst_byp");
    data_width = 2'b10;
    scr_bypass = 1'b1; send(32'h0000_0001); check("byp_w0",  scr_dout, 32'h0000_0001);
    scr_bypass = 1'b0; send(32'h0);         check("byp_hist", scr_dout, 32'h0400_0080);
    scr_bypass = 1'b1;
    data_width = 2'b00; send(32'hDEAD_BEEF); check("byp_8",  scr_dout, 32'h0000_00EF);
    data_width = 2'b01; send(32'hCAFE_F00D); check("byp_16", scr_dout, 32'h0000_F00D);

    // mid-stream reset, then restart from zero history
    apply_reset("rst_mid");
    data_width = 2'b10;
    send(32'h1); check("mid_w0", scr_dout, 32'h0000_0001);
    send(32'h0); check("mid_w1", scr_dout, 32'h0400_0080);

    // loopback at each width, bypass toggling, single-bit link error
    run_loop("loop8",    2'b00, 16, 1000, -10);
    run_loop("loop16",   2'b01, 16, 1000, -10);
    run_loop("loop32",   2'b10, 16, 1000, -10);
    run_loop("byp32",    2'b10, 16, 8,    -10);
    run_loop("byp8",     2'b00, 16, 8,    -10);
    run_loop("err32",    2'b10, 16, 1000, 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/scrambler.md
SCRAMBLER -- requirements
Module: scrambler

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; all other inputs are sampled on the rising clock edge.
REQ-002 Port: clk  input  1  rising-edge clock.
REQ-003 Port: reset  input  1  asynchronous active-high reset.
REQ-004 Port: dataWidth  input  2  word width select: 2'b00 = 8 bit, 2'b01 = 16 bit, 2'b10 = 32 bit, 2'b11 = 32 bit.
REQ-005 Port: din  input  32  payload word, LSB-aligned; bits above the active width are ignored.
REQ-006 Port: bypass  input  1  1 = pass data unscrambled.
REQ-007 Port: dout  output  32  registered scrambled word, LSB-aligned; bits above the active width are driven 0.

Function
REQ-008 Scrambling SHALL be multiplicative (self-synchronizing) with polynomial x^58 + x^39 + 1: y[n] = d[n] XOR y[n-39] XOR y[n-58], where n is the serial bit index.
REQ-009 Bits SHALL be processed LSB first: din bit 0 is serial bit n, and bit W-1 is bit n+W-1 (W = active width).
REQ-010 A 58-bit history register SHALL hold the last 58 transmitted bits; W bits are consumed per clock, so intra-word taps use bits of the current word.
REQ-011 dout SHALL register the W computed bits one clock after din is sampled (latency 1, one word per clock, no handshake).
REQ-012 With bypass=1, dout SHALL equal din (active width) registered with latency 1.
REQ-013 With bypass=1, history SHALL shift in the transmitted (unscrambled) bits, so a self-synchronizing receiver stays consistent.
REQ-014 A dataWidth change SHALL take effect on the next word with no history flush; the history simply shifts by the new W.
REQ-015 Companion descrambler (module descrambler, parameter WORDWIDTH = 8/16/32, default 32, same clk/reset/bypass ports, din/dout of WORDWIDTH bits) SHALL compute x[n] = y[n] XOR y[n-39] XOR y[n-58] over the received bits, LSB first.
REQ-016 The descrambler SHALL have 1-cycle registered latency, and its history SHALL always shift in received din bits, bypass or not.
REQ-017 With descrambler bypass=1, its dout SHALL equal its din, registered.
REQ-018 The descrambler SHALL self-synchronize: output is correct after at most 58 received bits following any history mismatch.

Reset
REQ-019 While reset is asserted, dout and the 58-bit history SHALL be all zeros in both modules, asynchronously.
REQ-020 Reset asserted mid-stream SHALL clear state immediately; scrambling SHALL restart from zero history on the first clock after release.

Structure
REQ-021 A shared package SHALL hold the tap constants (58, 39), the history length, and the dataWidth encodings.
REQ-022 The per-bit LFSR XOR SHALL be written as a width-generic combinational function/loop reused by both modules.
REQ-023 descrambler SHALL be a separate module; no further sub-module.

Verification
REQ-024 Reset, 32-bit mode, din = 0 continuously -> dout = 0x00000000 every cycle.
REQ-025 Reset, 32-bit mode, din = 0x00000001 then 0x00000000 -> dout = 0x00000001, then 0x04000080.
REQ-026 Reset, 8-bit mode, din = 0x01 then zeros -> words 1-3 = 0x00, word 4 = 0x80 (bit 39); word 7 has bit 2 set (bit 58).
REQ-027 Loopback at 8/16/32 bits: 32-bit counter into scrambler -> descrambler (same width) -> descrambler dout = counter delayed exactly 2 clocks, from the first word after reset.
REQ-028 Loopback with bypass toggled 0->1 on both modules mid-stream -> scrambler dout = din delayed 1 clock; descrambler output = counter delayed 2 clocks.
REQ-029 Single bit flip injected on the link -> descrambler errors only at that bit and at offsets +39 and +58, then error-free.
